alu_responder: RTL and testbench

- Sequential responder for the yAlu request interface: accepts operand/opcode requests on a valid/ready channel and returns results on a second valid/ready channel.
- Computes the result at request acceptance and queues it in a DEPTH-entry response FIFO.
- Sits between a stimulus/initiator (bench or sequencer) and any result consumer; lets the ALU be driven at full rate while absorbing consumer stalls.

---
 rtl/alu_responder_if.sv | 26 ++
 rtl/alu_responder.sv | 99 +++++++++
 tb/tb_alu_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_responder_if.sv
// rtl/alu_responder_if.sv - request/response handshake bundle for alu_responder
interface alu_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_ex;
  logic             rsp_err;
  logic [15:0]      op_count;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_ex, rsp_err, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_ex, rsp_err, op_count
  );
endinterface

// File: rtl/alu_responder.sv
// rtl/alu_responder.sv - ALU responder computing at request accept into a DEPTH-entry response FIFO
// Optional: ALU_RESPONDER_SLT_EN makes opcode 111 a signed less-than.
module alu_responder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  alu_responder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_z_q [DEPTH];
  logic [DEPTH-1:0] mem_ex_q;
  logic [DEPTH-1:0] mem_err_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      op_count_q, op_count_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] z_d;
  logic             ex_d;
  logic             err_d;

  always_comb begin
    z_d   = '0;
    err_d = 1'b0;
    case (bus.req_op)
      3'b000: z_d = bus.req_a & bus.req_b;
      3'b001: z_d = bus.req_a | bus.req_b;
      3'b010: z_d = bus.req_a + bus.req_b;
      3'b110: z_d = bus.req_a - bus.req_b;
`ifdef ALU_RESPONDER_SLT_EN
      3'b111: z_d = {{(WIDTH-1){1'b0}}, ($signed(bus.req_a) < $signed(bus.req_b))};
`endif
      default: err_d = 1'b1;
    endcase
    ex_d = (z_d == '0);
  end

  // Ready depends only on registered occupancy: a pop while full frees a slot next cycle.
  assign bus.req_ready = (count_q < DEPTH_C);
  assign bus.rsp_valid = (count_q != '0);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign bus.rsp_z    = mem_z_q[rd_ptr_q];
  assign bus.rsp_ex   = mem_ex_q[rd_ptr_q];
  assign bus.rsp_err  = mem_err_q[rd_ptr_q];
  assign bus.op_count = op_count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    op_count_d = op_count_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      op_count_d = op_count_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head outputs read zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_z_q[i] <= '0;
      end
      mem_ex_q   <= '0;
      mem_err_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
    end else begin
      if (push) begin
        mem_z_q[wr_ptr_q]   <= z_d;
        mem_ex_q[wr_ptr_q]  <= ex_d;
        mem_err_q[wr_ptr_q] <= err_d;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end
endmodule

// File: tb/tb_alu_responder.sv
// tb/tb_alu_responder.sv - randomized self-checking bench for alu_responder
module tb_alu_responder;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   exp_opcnt;

  alu_responder_if #(.WIDTH(WIDTH)) bus ();

  alu_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {err, ex, z} from the opcode table using plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint unsigned m;
    longint sa;
    longint sb;
    logic [31:0] z;
    logic err;
    m   = 64'h1_0000_0000;
    z   = 32'd0;
    err = 1'b0;
    sa  = a[31] ? longint'(a) - longint'(m) : longint'(a);
    sb  = b[31] ? longint'(b) - longint'(m) : longint'(b);
    case (op)
      3'd0: z = a & b;
      3'd1: z = a | b;
      3'd2: z = 32'((longint'(a) + longint'(b)) % m);
      3'd6: z = 32'((longint'(a) + longint'(m) - longint'(b)) % m);
`ifdef ALU_RESPONDER_SLT_EN
      3'd7: z = (sa < sb) ? 32'd1 : 32'd0;
`endif
      default: err = 1'b1;
    endcase
    if (sa == sb && op == 3'd5) z = 32'd0;
    return {err, (z == 32'd0), z};
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (n >= 20) begin
      n_bad++;
      $display("FAIL issue_timeout req_ready=%b want 1", bus.req_ready);
    end else begin
      @(posedge clk); #1;
      exp_opcnt++;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.op_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_in rsp_valid=%b op_count=%0d want 0/0", bus.rsp_valid, bus.op_count);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    exp_opcnt = 0;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs req_ready=%b rsp_valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
    end
    n_cmp++;
    if ({bus.rsp_z, bus.rsp_ex, bus.rsp_err} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_rsp z=%h ex=%b err=%b want 0/0/0", bus.rsp_z, bus.rsp_ex, bus.rsp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [33:0] want);
    logic [33:0] got;
    bus.rsp_ready = 1'b1;
    issue(a, b, op);
    got = {bus.rsp_err, bus.rsp_ex, bus.rsp_z};
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || got !== want) begin
      n_bad++;
      $display("FAIL %s valid=%b err/ex/z=%h want 1 %h", name, bus.rsp_valid, got, want);
    end
    n_cmp++;
    if (bus.op_count !== 16'(exp_opcnt)) begin
      n_bad++;
      $display("FAIL %s_opcnt got %0d want %0d", name, bus.op_count, exp_opcnt);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain rsp_valid=%b want 0", name, bus.rsp_valid);
    end
  endtask

  task automatic test_backpressure;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_a = 32'hF0; bus.req_b = 32'h3C; bus.req_op = 3'd0;
    @(posedge clk); #1;
    bus.req_a = 32'hF0; bus.req_b = 32'h0F; bus.req_op = 3'd1;
    @(posedge clk); #1;
    bus.req_a = 32'd1; bus.req_b = 32'd1; bus.req_op = 3'd2;
    exp_opcnt += 2;
    n_cmp++;
    if (bus.req_ready !== 1'b0 || bus.rsp_z !== 32'h30 || bus.op_count !== 16'(exp_opcnt)) begin
      n_bad++;
      $display("FAIL bp_full req_ready=%b z=%h opcnt=%0d want 0 30 %0d", bus.req_ready, bus.rsp_z, bus.op_count, exp_opcnt);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_z !== 32'h30 || bus.req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_hold valid=%b z=%h ready=%b want 1 30 0", bus.rsp_valid, bus.rsp_z, bus.req_ready);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.rsp_z !== 32'hFF || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_pop1 z=%h ready=%b want ff 1", bus.rsp_z, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    exp_opcnt++;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_z !== 32'd2 || bus.op_count !== 16'(exp_opcnt)) begin
      n_bad++;
      $display("FAIL bp_third valid=%b z=%h opcnt=%0d want 1 2 %0d", bus.rsp_valid, bus.rsp_z, bus.op_count, exp_opcnt);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_empty rsp_valid=%b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_stream;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [33:0] exp_q[$];
    logic [33:0] want;
    int start;
    start = exp_opcnt;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a  = $urandom;
      b  = (i == 3) ? a : $urandom;
      op = 3'($urandom_range(0, 7));
      bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_op = op;
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL stream_stall cycle %0d req_ready=%b want 1", i, bus.req_ready);
      end
      @(posedge clk); #1;
      exp_opcnt++;
      exp_q.push_back(model(a, b, op));
      want = exp_q.pop_front();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || {bus.rsp_err, bus.rsp_ex, bus.rsp_z} !== want) begin
        n_bad++;
        $display("FAIL stream_rsp %0d valid=%b got %h want %h", i, bus.rsp_valid,
                 {bus.rsp_err, bus.rsp_ex, bus.rsp_z}, want);
      end
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (bus.op_count !== 16'(start + 10)) begin
      n_bad++;
      $display("FAIL stream_opcnt got %0d want %0d", bus.op_count, start + 10);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_bp;
    logic [33:0] exp_q[$];
    logic        acc;
    logic        pop;
    for (int i = 0; i < 80; i++) begin
      n_cmp++;
      if (bus.rsp_valid !== (exp_q.size() != 0) || bus.req_ready !== (exp_q.size() < DEPTH)) begin
        n_bad++;
        $display("FAIL rbp_flags %0d valid=%b ready=%b occ=%0d", i, bus.rsp_valid, bus.req_ready, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({bus.rsp_err, bus.rsp_ex, bus.rsp_z} !== exp_q[0]) begin
          n_bad++;
          $display("FAIL rbp_head %0d got %h want %h", i, {bus.rsp_err, bus.rsp_ex, bus.rsp_z}, exp_q[0]);
        end
      end
      if (!bus.req_valid) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_op    = 3'($urandom_range(0, 7));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      if (i >= 70) begin
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
      end
      acc = bus.req_valid && (exp_q.size() < DEPTH);
      pop = bus.rsp_ready && (exp_q.size() != 0);
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(model(bus.req_a, bus.req_b, bus.req_op));
        exp_opcnt++;
      end
      @(posedge clk); #1;
      if (acc) bus.req_valid = 1'b0;
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.op_count !== 16'(exp_opcnt)) begin
      n_bad++;
      $display("FAIL rbp_end valid=%b opcnt=%0d want 0 %0d", bus.rsp_valid, bus.op_count, exp_opcnt);
    end
  endtask

  task automatic test_async_reset;
    bus.rsp_ready = 1'b0;
    issue(32'd10, 32'd20, 3'd2);
    issue(32'd30, 32'd40, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.op_count !== 16'd0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL areset valid=%b opcnt=%0d ready=%b want 0 0 1", bus.rsp_valid, bus.op_count, bus.req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_opcnt = 0;
    test_single("post_reset_or", 32'd1, 32'd2, 3'd1, {1'b0, 1'b0, 32'd3});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_opcnt = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single("add", 32'd5, 32'd3, 3'd2, {1'b0, 1'b0, 32'd8});
    test_single("sub_zero", 32'h12345678, 32'h12345678, 3'd6, {1'b0, 1'b1, 32'd0});
    test_single("sub_wrap", 32'd0, 32'd1, 3'd6, {1'b0, 1'b0, 32'hFFFFFFFF});
    test_single("illegal", 32'd7, 32'd9, 3'd3, {1'b1, 1'b1, 32'd0});
`ifdef ALU_RESPONDER_SLT_EN
    test_single("slt", 32'hFFFFFFFF, 32'd1, 3'd7, {1'b0, 1'b0, 32'd1});
`else
    test_single("op7_illegal", 32'hFFFFFFFF, 32'd1, 3'd7, {1'b1, 1'b1, 32'd0});
`endif
    test_backpressure();
    test_stream();
    test_random_bp();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
